uart_tx_feeder: RTL and testbench

Buffered front end for the UART transmitter. Accepts bytes from the CPU/peripheral bus into a FIFO and issues them one at a time to `uart_tx` through its start/in-progress/done handshake, so software can post a burst of bytes without polling per byte. It sits between the memory-mapped UART register block (upstream) and `uart_tx` (downstream).

---
 rtl/uart_tx_feeder.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//
// Buffered front end for uart_tx. Bytes posted by the UART register block are
// queued in a small circular FIFO. They are handed to uart_tx one at a time
// through its start / in-progress / done handshake, so software can post a
// burst without polling per byte.
//
// Parameters
//   DEPTH            FIFO entries (power of two, >= 2)
//
// Ports
//   i_Clk            system clock
//   i_Rst_L          asynchronous, active-low reset (shared with uart_tx)
//   i_Wr_En          write strobe, one byte per cycle
//   i_Wr_Data        byte to enqueue
//   i_Flush          synchronous clear of the queued bytes
//   i_Clr_Overflow   clears o_Overflow
//   o_Full           FIFO holds DEPTH bytes
//   o_Empty          FIFO holds no bytes
//   o_Count          bytes queued, excluding the byte already handed to the TX
//   o_Overflow       sticky: a write was dropped because the FIFO was full
//   o_Busy           bytes queued, or a byte is still in flight
//   o_TX_Byte        byte presented to uart_tx, stable until the next pop
//   o_TX_Start       one-cycle start pulse to uart_tx
//   i_TX_InProgress  uart_tx is shifting a frame
//   i_TX_Done        uart_tx is idle
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DEPTH = 16
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_Wr_En,
    input  logic [7:0]             i_Wr_Data,
    input  logic                   i_Flush,
    input  logic                   i_Clr_Overflow,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [$clog2(DEPTH):0] o_Count,
    output logic                   o_Overflow,
    output logic                   o_Busy,
    output logic [7:0]             o_TX_Byte,
    output logic                   o_TX_Start,
    input  logic                   i_TX_InProgress,
    input  logic                   i_TX_Done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_START_PULSE = 2'd1;
    localparam logic [1:0] ST_WAIT_ACCEPT = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE   = 2'd3;

    // Pointer arithmetic relies on natural wrap of AW-bit counters.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_feeder: DEPTH must be a power of two and at least 2");
    end

    // Storage is never reset; only the pointers/count define validity.
    logic [7:0]    mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    state_q, state_d;
    logic          start_q, start_d;
    logic [7:0]    tx_byte_q, tx_byte_d;

    logic          wr_accept;
    logic          wr_drop;
    logic          pop;

    // A write while full is dropped even if a pop frees a slot this cycle,
    // because full_q reflects the count before the edge.
    assign wr_accept = i_Wr_En & ~full_q & ~i_Flush;
    assign wr_drop   = i_Wr_En & full_q;

    // The only pop is the IDLE -> START_PULSE hand-off.
    assign pop = (state_q == ST_IDLE) & ~empty_q & i_TX_Done & ~i_TX_InProgress;

    // -------------------------------------------------------------------------
    // FIFO bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_Flush) begin
            // A pop in the same cycle still launches its byte; only the
            // queued contents are discarded.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Set wins over a same-cycle clear so no drop event is ever lost.
    always_comb begin
        ovf_d = ovf_q;
        if (i_Clr_Overflow) begin
            ovf_d = 1'b0;
        end
        if (wr_drop) begin
            ovf_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Hand-off FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tx_byte_d = mem_q[rd_ptr_q];
                    start_d   = 1'b1;
                    state_d   = ST_START_PULSE;
                end
            end
            ST_START_PULSE: begin
                // uart_tx latches the byte on this edge; its in-progress
                // flag follows one cycle later.
                state_d = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
                if (i_TX_InProgress) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_TX_Done && !i_TX_InProgress) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            start_q   <= start_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= i_Wr_Data;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_Full     = full_q;
    assign o_Empty    = empty_q;
    assign o_Count    = count_q;
    assign o_Overflow = ovf_q;
    assign o_TX_Byte  = tx_byte_q;
    assign o_TX_Start = start_q;

    // Includes the live in-progress flag so the feeder reads busy until the
    // downstream frame has actually finished.
    assign o_Busy = ~empty_q | (state_q != ST_IDLE) | i_TX_InProgress;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for uart_tx_feeder.
//
// A behavioural stand-in for uart_tx (CLKS_PER_BIT = 4, 10-bit frame, so it is
// in progress for 40 cycles) answers the start pulses and logs every byte it
// latches. A queue-based model of the feeder predicts the outputs, which are
// compared every cycle on the falling clock edge; directed sections add
// literal expectations for reset, single byte, burst, overflow, wrap, flush
// and reset mid-transfer.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 40;   // 4 clocks/bit * 10 bits
    // Start pulse edge -> latch edge (1) + FRAME in progress + 2 cycles back to
    // the next pulse = 43 cycles between consecutive start pulses.
    localparam int SPACING = 43;

    logic          clk = 1'b0;
    logic          rst_l = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          flush = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          tx_active = 1'b0;
    logic          hold_busy = 1'b0;

    logic          full, empty, ovf, busy, tx_start;
    logic [CW-1:0] count;
    logic [7:0]    tx_byte;
    logic          tx_inprog, tx_done;

    // uart_tx shares the reset, so its in-progress flag drops with it.
    assign tx_inprog = (tx_active & rst_l) | hold_busy;
    assign tx_done   = ~tx_inprog;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .i_Clk           (clk),
        .i_Rst_L         (rst_l),
        .i_Wr_En         (wr_en),
        .i_Wr_Data       (wr_data),
        .i_Flush         (flush),
        .i_Clr_Overflow  (clr_ovf),
        .o_Full          (full),
        .o_Empty         (empty),
        .o_Count         (count),
        .o_Overflow      (ovf),
        .o_Busy          (busy),
        .o_TX_Byte       (tx_byte),
        .o_TX_Start      (tx_start),
        .i_TX_InProgress (tx_inprog),
        .i_TX_Done       (tx_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // -------------------------------------------------------------------------
    // uart_tx stand-in: logs latched bytes and start-pulse cycles
    // -------------------------------------------------------------------------
    logic [7:0] rx_log[$];
    int         start_t[$];
    logic [7:0] rx_b;
    bit         rx_abort;

    initial forever begin
        @(negedge clk);
        if (rst_l && tx_start) begin
            start_t.push_back(cyc);
            rx_b = tx_byte;
            @(posedge clk);
            if (rst_l) begin
                #1 tx_active = 1'b1;
                rx_abort = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    @(posedge clk);
                    if (!rst_l) begin
                        rx_abort = 1'b1;
                        break;
                    end
                end
                #1 tx_active = 1'b0;
                if (!rx_abort) rx_log.push_back(rx_b);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Feeder model: queue of pending bytes plus the life cycle of the byte in
    // flight (pulse cycle, waiting for the TX to take it, waiting for done).
    // -------------------------------------------------------------------------
    logic [7:0] mq[$];
    bit         m_ovf, m_flight, m_pulse, m_acc, m_start, m_pop;
    logic [7:0] m_byte;
    int         m_pre;

    initial begin
        m_ovf = 0; m_flight = 0; m_pulse = 0; m_acc = 0; m_start = 0; m_byte = 8'h00;
        forever begin
            @(posedge clk or negedge rst_l);
            if (!rst_l) begin
                mq.delete();
                m_ovf = 0; m_flight = 0; m_pulse = 0; m_acc = 0;
                m_start = 0; m_byte = 8'h00;
            end else begin
                m_pre = mq.size();
                m_pop = 0;
                if (m_flight) begin
                    if (m_pulse)                      m_pulse = 0;
                    else if (!m_acc)                  m_acc = tx_inprog;
                    else if (tx_done && !tx_inprog)   m_flight = 0;
                end else if (m_pre > 0 && tx_done && !tx_inprog) begin
                    m_pop = 1;
                end
                m_start = m_pop;
                if (m_pop) begin
                    m_byte   = mq.pop_front();
                    m_flight = 1; m_pulse = 1; m_acc = 0;
                end
                if (wr_en && m_pre == DEPTH) m_ovf = 1;
                else if (clr_ovf)            m_ovf = 0;
                if (flush)                                  mq.delete();
                else if (wr_en && m_pre < DEPTH)            mq.push_back(wr_data);
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("count",    int'(count),    mq.size());
        chk("empty",    int'(empty),    int'(mq.size() == 0));
        chk("full",     int'(full),     int'(mq.size() == DEPTH));
        chk("overflow", int'(ovf),      int'(m_ovf));
        chk("tx_start", int'(tx_start), int'(m_start));
        chk("tx_byte",  int'(tx_byte),  int'(m_byte));
        chk("busy",     int'(busy),     int'(mq.size() > 0 || m_flight || tx_inprog));
    end

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    task automatic wait_idle(input string nm, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk({nm, "_timeout"}, 1, 0);
    endtask

    task automatic write_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'(first + i);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check_outputs_reset(input string nm);
        chk({nm, "_start"}, int'(tx_start), 0);
        chk({nm, "_byte"},  int'(tx_byte),  0);
        chk({nm, "_empty"}, int'(empty),    1);
        chk({nm, "_full"},  int'(full),     0);
        chk({nm, "_count"}, int'(count),    0);
        chk({nm, "_ovf"},   int'(ovf),      0);
        chk({nm, "_busy"},  int'(busy),     0);
    endtask

    int  n_sent, n_simul;
    bit  pn;

    initial begin
        // ---- reset ----
        #2 rst_l = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_reset("rst");
        rst_l = 1'b1;

        // ---- single byte ----
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);                       // after write edge k
        wr_en = 1'b0;
        chk("single_empty_k",  int'(empty),    0);
        chk("single_start_k",  int'(tx_start), 0);
        @(negedge clk);                       // after edge k+1
        chk("single_start_k1", int'(tx_start), 1);
        chk("single_byte_k1",  int'(tx_byte),  8'hA5);
        @(negedge clk);                       // after edge k+2
        chk("single_start_k2", int'(tx_start), 0);
        chk("single_inprog",   int'(tx_inprog), 1);
        wait_idle("single", 300);
        chk("single_nframes", rx_log.size(), 1);
        chk("single_frame",   int'(rx_log[0]), 8'hA5);
        chk("single_npulses", start_t.size(), 1);

        // ---- burst 0x01..0x10 ----
        rx_log.delete(); start_t.delete();
        write_seq(8'h01, 16);
        chk("burst_ovf", int'(ovf), 0);
        wait_idle("burst", 16 * SPACING + 200);
        chk("burst_nframes", rx_log.size(), 16);
        for (int i = 0; i < 16 && i < rx_log.size(); i++)
            chk("burst_order", int'(rx_log[i]), i + 1);
        for (int i = 1; i < start_t.size(); i++)
            chk("burst_spacing", start_t[i] - start_t[i-1], SPACING);

        // ---- overflow with TX held busy ----
        rx_log.delete(); start_t.delete();
        @(negedge clk);
        hold_busy = 1'b1;
        write_seq(8'h80, 18);
        chk("ovf_full",  int'(full),  1);
        chk("ovf_count", int'(count), 16);
        chk("ovf_flag",  int'(ovf),   1);
        wr_en = 1'b1; wr_data = 8'h92; clr_ovf = 1'b1;   // set beats clear
        @(negedge clk);
        wr_en = 1'b0;
        chk("ovf_set_wins", int'(ovf), 1);
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);
        hold_busy = 1'b0;
        wait_idle("ovf", 16 * SPACING + 200);
        chk("ovf_nframes", rx_log.size(), 16);
        for (int i = 0; i < 16 && i < rx_log.size(); i++)
            chk("ovf_order", int'(rx_log[i]), 8'h80 + i);

        // ---- wrap with writes on pop cycles ----
        rx_log.delete(); start_t.delete();
        n_sent = 0; n_simul = 0;
        for (int c = 0; c < 3000 && n_sent < 52; c++) begin
            @(negedge clk);
            pn = !m_flight && mq.size() > 0 && !tx_inprog;
            if (pn || mq.size() < 3) begin
                wr_en   = 1'b1;
                wr_data = 8'(8'h40 + n_sent);
                n_sent++;
                if (pn) n_simul++;
            end else begin
                wr_en = 1'b0;
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("wrap_simul", int'(n_simul >= 3), 1);
        wait_idle("wrap", 8 * SPACING);
        chk("wrap_nframes", rx_log.size(), 52);
        for (int i = 0; i < 52 && i < rx_log.size(); i++)
            chk("wrap_order", int'(rx_log[i]), 8'h40 + i);

        // ---- flush during first frame ----
        rx_log.delete(); start_t.delete();
        write_seq(8'hC0, 5);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        wait_idle("flush", 3 * SPACING);
        chk("flush_nframes", rx_log.size(), 1);
        if (rx_log.size() > 0) chk("flush_frame", int'(rx_log[0]), 8'hC0);
        chk("flush_npulses", start_t.size(), 1);

        // ---- reset mid-transfer ----
        rx_log.delete(); start_t.delete();
        write_seq(8'hD0, 3);
        repeat (10) @(negedge clk);
        #3 rst_l = 1'b0;
        #1 check_outputs_reset("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_nostart", int'(tx_start), 0);
        end
        rst_l = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_nframes", rx_log.size(), 0);
        chk("midrst_busy",    int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
